// File: rtl/i2c_slave_responder.sv
// I2C target serving a byte register file with an auto-incrementing pointer; SDA is driven open-drain only.
// Define GENERAL_CALL_EN to ACK general-call (8'h00) writes and report their bytes without touching ptr/mem.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h22,
    parameter int         MEM_DEPTH   = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       start_det_o,
    output logic       stop_det_o,
    output logic       byte_rx_valid_o,
    output logic [7:0] byte_rx_o,
    output logic       busy_o,
    output logic       nack_rx_o
);
    localparam int PTR_W = $clog2(MEM_DEPTH);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
    logic                   sclPrev_q, sdaPrev_q;
    logic                   scl, sda, sclRise, sclFall, startSeen, stopSeen;
    logic                   addrHit, gcHit;
    logic [7:0]             shift_d;

    state_t                 state_q;
    logic [2:0]             bitCnt_q;
    logic [6:0]             shift_q;
    logic [6:0]             txByte_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [7:0]             mem_q [MEM_DEPTH];
    logic                   rw_q, wrActive_q, gc_q;
    logic                   sdaOe_q, busy_q, startDet_q, stopDet_q, rxValid_q, nack_q;
    logic [7:0]             rxByte_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
            sclPrev_q <= sclSync_q[SYNC_STAGES-1];
            sdaPrev_q <= sdaSync_q[SYNC_STAGES-1];
        end
    end

    assign scl       = sclSync_q[SYNC_STAGES-1];
    assign sda       = sdaSync_q[SYNC_STAGES-1];
    assign sclRise   = scl & ~sclPrev_q;
    assign sclFall   = ~scl & sclPrev_q;
    assign startSeen = scl & sclPrev_q & sdaPrev_q & ~sda;
    assign stopSeen  = scl & sclPrev_q & ~sdaPrev_q & sda;
    assign shift_d   = {shift_q, sda};
    assign addrHit   = (shift_d[7:1] == SLAVE_ADDR);

`ifdef GENERAL_CALL_EN
    assign gcHit = (shift_d == 8'h00);
`else
    assign gcHit = 1'b0;
`endif

    // START/STOP take priority over any SCL edge; ACK states use sdaOe_q to tell the 8th fall from the 9th.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            txByte_q   <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            wrActive_q <= 1'b0;
            gc_q       <= 1'b0;
            sdaOe_q    <= 1'b0;
            busy_q     <= 1'b0;
            startDet_q <= 1'b0;
            stopDet_q  <= 1'b0;
            rxValid_q  <= 1'b0;
            nack_q     <= 1'b0;
            rxByte_q   <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            startDet_q <= 1'b0;
            stopDet_q  <= 1'b0;
            rxValid_q  <= 1'b0;
            nack_q     <= 1'b0;
            if (startSeen) begin
                state_q    <= ADDR;
                bitCnt_q   <= '0;
                sdaOe_q    <= 1'b0;
                busy_q     <= 1'b0;
                gc_q       <= 1'b0;
                startDet_q <= 1'b1;
            end else if (stopSeen) begin
                state_q    <= IDLE;
                sdaOe_q    <= 1'b0;
                busy_q     <= 1'b0;
                gc_q       <= 1'b0;
                wrActive_q <= 1'b0;
                stopDet_q  <= 1'b1;
            end else begin
                if (sclRise) shift_q <= shift_d[6:0];
                unique case (state_q)
                    ADDR: if (sclRise) begin
                        bitCnt_q <= bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            if (addrHit || gcHit) begin
                                state_q <= ADDR_ACK;
                                busy_q  <= 1'b1;
                                rw_q    <= shift_d[0];
                                gc_q    <= gcHit;
                            end else begin
                                state_q    <= IGNORE;
                                wrActive_q <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: if (sclFall) begin
                        if (!sdaOe_q) begin
                            sdaOe_q <= 1'b1;
                        end else begin
                            bitCnt_q <= '0;
                            if (rw_q) begin
                                state_q    <= RD_BYTE;
                                txByte_q   <= mem_q[ptr_q][6:0];
                                sdaOe_q    <= ~mem_q[ptr_q][7];
                                wrActive_q <= 1'b0;
                            end else begin
                                sdaOe_q <= 1'b0;
                                if (wrActive_q || gc_q) begin
                                    state_q <= WR_BYTE;
                                end else begin
                                    state_q    <= PTR;
                                    wrActive_q <= 1'b1;
                                end
                            end
                        end
                    end
                    PTR, WR_BYTE: if (sclRise) begin
                        bitCnt_q <= bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            state_q   <= WR_ACK;
                            rxByte_q  <= shift_d;
                            rxValid_q <= 1'b1;
                            if (state_q == PTR) begin
                                ptr_q <= shift_d[PTR_W-1:0];
                            end else if (!gc_q) begin
                                mem_q[ptr_q] <= shift_d;
                                ptr_q        <= ptr_q + 1'b1;
                            end
                        end
                    end
                    WR_ACK: if (sclFall) begin
                        if (!sdaOe_q) begin
                            sdaOe_q <= 1'b1;
                        end else begin
                            sdaOe_q <= 1'b0;
                            state_q <= WR_BYTE;
                        end
                    end
                    RD_BYTE: if (sclFall) begin
                        if (bitCnt_q == 3'd7) begin
                            sdaOe_q  <= 1'b0;
                            ptr_q    <= ptr_q + 1'b1;
                            bitCnt_q <= '0;
                            state_q  <= RD_ACK;
                        end else begin
                            sdaOe_q  <= ~txByte_q[6];
                            txByte_q <= {txByte_q[5:0], 1'b0};
                            bitCnt_q <= bitCnt_q + 3'd1;
                        end
                    end
                    RD_ACK: begin
                        if (sclRise && sda) begin
                            nack_q  <= 1'b1;
                            state_q <= IGNORE;
                        end else if (sclFall) begin
                            state_q  <= RD_BYTE;
                            txByte_q <= mem_q[ptr_q][6:0];
                            sdaOe_q  <= ~mem_q[ptr_q][7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe_o        = sdaOe_q;
    assign start_det_o     = startDet_q;
    assign stop_det_o      = stopDet_q;
    assign byte_rx_valid_o = rxValid_q;
    assign byte_rx_o       = rxByte_q;
    assign busy_o          = busy_q;
    assign nack_rx_o       = nack_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Self-checking bench for i2c_slave_responder: a bit-banged I2C master plus a register-file reference model.
module tb_i2c_slave_responder;
    localparam int Q = 6;
`ifdef GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       sclM  = 1'b1;
    logic       sdaM  = 1'b1;
    logic       sdaBus;
    logic       sda_oe_o, start_det_o, stop_det_o, byte_rx_valid_o, busy_o, nack_rx_o;
    logic [7:0] byte_rx_o;

    assign sdaBus = sdaM & ~sda_oe_o;

    i2c_slave_responder dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .scl_i          (sclM),
        .sda_i          (sdaBus),
        .sda_oe_o       (sda_oe_o),
        .start_det_o    (start_det_o),
        .stop_det_o     (stop_det_o),
        .byte_rx_valid_o(byte_rx_valid_o),
        .byte_rx_o      (byte_rx_o),
        .busy_o         (busy_o),
        .nack_rx_o      (nack_rx_o)
    );

    always #5 clk_i = ~clk_i;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] rxQ[$];
    int         stopCnt = 0, nackCnt = 0, oeCnt = 0;
    logic [7:0] model[16];
    int         mPtr = 0;
    logic [7:0] wrBuf[$];

    // Monitor: records received bytes and counts pulses, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (byte_rx_valid_o) rxQ.push_back(byte_rx_o);
        if (stop_det_o) stopCnt++;
        if (nack_rx_o) nackCnt++;
        if (sda_oe_o) oeCnt++;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitQ();
        repeat (Q) @(posedge clk_i);
        #1;
    endtask

    task automatic sendBit(input logic b);
        sdaM = b; waitQ(); sclM = 1'b1; waitQ(); waitQ(); sclM = 1'b0; waitQ();
    endtask

    task automatic recvBit(output logic b);
        sdaM = 1'b1; waitQ(); sclM = 1'b1; waitQ(); b = sdaBus; waitQ(); sclM = 1'b0; waitQ();
    endtask

    task automatic i2cStart();
        sdaM = 1'b1; waitQ(); sclM = 1'b1; waitQ(); sdaM = 1'b0; waitQ(); sclM = 1'b0; waitQ();
    endtask

    task automatic i2cStop();
        sdaM = 1'b0; waitQ(); sclM = 1'b1; waitQ(); sdaM = 1'b1; waitQ();
    endtask

    task automatic sendByte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) sendBit(d[i]);
        recvBit(b);
        ack = ~b;
    endtask

    task automatic recvByte(output logic [7:0] d, output logic oe9, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recvBit(b);
            d[i] = b;
        end
        sdaM = ~ack; waitQ(); sclM = 1'b1; waitQ(); oe9 = sda_oe_o; waitQ(); sclM = 1'b0; waitQ();
    endtask

    // Write transaction of wrBuf to addrByte; the model treats the first byte as the pointer.
    task automatic applyStimulus(input logic [7:0] addrByte);
        logic ack, hit, gc, acked;
        int   rx0, oe0, stop0, expN;
        rx0   = rxQ.size();
        oe0   = oeCnt;
        stop0 = stopCnt;
        hit   = (addrByte[7:1] == 7'h22) && !addrByte[0];
        gc    = (addrByte == 8'h00) && GC_EN;
        acked = hit | gc;
        i2cStart();
        sendByte(addrByte, ack);
        checkOutput("addrAck", int'(ack), int'(acked));
        checkOutput("busyActive", int'(busy_o), int'(acked));
        foreach (wrBuf[i]) begin
            sendByte(wrBuf[i], ack);
            checkOutput("dataAck", int'(ack), int'(acked));
        end
        i2cStop();
        checkOutput("stopDet", stopCnt - stop0, 1);
        checkOutput("busyIdle", int'(busy_o), 0);
        expN = acked ? wrBuf.size() : 0;
        checkOutput("rxCount", rxQ.size() - rx0, expN);
        for (int i = 0; i < expN; i++)
            if (rx0 + i < rxQ.size()) checkOutput("rxByte", int'(rxQ[rx0 + i]), int'(wrBuf[i]));
        if (!acked) checkOutput("noDrive", oeCnt - oe0, 0);
        if (hit) begin
            foreach (wrBuf[i]) begin
                if (i == 0) mPtr = int'(wrBuf[i]) % 16;
                else begin
                    model[mPtr] = wrBuf[i];
                    mPtr = (mPtr + 1) % 16;
                end
            end
        end
    endtask

    // Set pointer, repeated START as reader, ACK all but the last byte, then STOP.
    task automatic readBack(input logic [7:0] p, input int n);
        logic       ack, oe9;
        logic [7:0] d;
        int         nack0;
        nack0 = nackCnt;
        i2cStart();
        sendByte(8'h44, ack); checkOutput("rdAddrW", int'(ack), 1);
        sendByte(p, ack);     checkOutput("rdPtrAck", int'(ack), 1);
        mPtr = int'(p) % 16;
        i2cStart();
        sendByte(8'h45, ack); checkOutput("rdAddrR", int'(ack), 1);
        for (int i = 0; i < n; i++) begin
            recvByte(d, oe9, i != n - 1);
            checkOutput("rdData", int'(d), int'(model[mPtr]));
            checkOutput("rdRelease", int'(oe9), 0);
            mPtr = (mPtr + 1) % 16;
        end
        i2cStop();
        checkOutput("nackPulse", nackCnt - nack0, 1);
    endtask

    function automatic int allOutputs();
        return int'({sda_oe_o, start_det_o, stop_det_o, byte_rx_valid_o, busy_o, nack_rx_o, byte_rx_o});
    endfunction

    initial begin
        logic       ack;
        logic [7:0] a;
        int         n;
        foreach (model[i]) model[i] = 8'h00;
        repeat (4) @(posedge clk_i);
        #1;
        checkOutput("resetOutputs", allOutputs(), 0);
        rst_i = 1'b1;
        waitQ();
        checkOutput("postResetOutputs", allOutputs(), 0);

        wrBuf = '{8'h03, 8'hA5, 8'h5A};
        applyStimulus(8'h44);
        readBack(8'h03, 2);

        wrBuf = '{8'h11};
        applyStimulus(8'h46);

        wrBuf = '{8'h0F, 8'h01, 8'h02, 8'h03};
        applyStimulus(8'h44);
        readBack(8'h0F, 3);

        wrBuf = '{8'h06};
        applyStimulus(8'h00);

        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(1, 4);
            wrBuf = {};
            case ($urandom_range(0, 3))
                0: begin
                    a = 8'($urandom_range(0, 255));
                    if (a[7:1] == 7'h22 || a == 8'h00) a = a ^ 8'h80;
                    for (int i = 0; i < n; i++) wrBuf.push_back(8'($urandom_range(0, 255)));
                    applyStimulus(a);
                end
                3: readBack(8'($urandom_range(0, 255)), n);
                default: begin
                    for (int i = 0; i <= n; i++) wrBuf.push_back(8'($urandom_range(0, 255)));
                    applyStimulus(8'h44);
                end
            endcase
        end
        readBack(8'h00, 17);

        // Reset while SCL is high on bit 4 of a data byte.
        i2cStart();
        sendByte(8'h44, ack);
        sendByte(8'h07, ack);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        sdaM = 1'b0; waitQ(); sclM = 1'b1; waitQ();
        rst_i = 1'b0;
        #1;
        checkOutput("midResetOutputs", allOutputs(), 0);
        sdaM = 1'b1;
        waitQ();
        rst_i = 1'b1;
        waitQ();
        foreach (model[i]) model[i] = 8'h00;
        readBack(8'h05, 4);

        wrBuf = '{8'h03, 8'hA5, 8'h5A};
        applyStimulus(8'h44);
        readBack(8'h02, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
